y86_writeback_pc_update: RTL
============================

Name: y86_writeback_pc_update

Overview:
- Final SEQ stage, directly downstream of the data-memory stage; consumes its valM and dmem_error plus execute results (valE, cnd).
- Owns the architectural state:
  - 15-entry x 64-bit register file, with two combinational read ports serving decode.
  - Program counter register.
  - Sticky processor status (Stat).
  - Retired-instruction counter.
- Commits one instruction per rising clk edge unless the processor has stopped.

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.
- RSP_INIT, 64'd1000, %rsp (reg 4) value loaded on reset; all other registers reset to 0.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- icode  in  4  current instruction code.
- rA  in  4  register A field (0xF = none).
- rB  in  4  register B field (0xF = none).
- cnd  in  1  condition result from execute (jXX/cmovXX).
- valE  in  64  ALU result.
- valM  in  64  data read by memory stage.
- valC  in  64  instruction constant.
- valP  in  64  fall-through PC.
- instr_valid  in  1  fetch decoded a legal icode/ifun.
- imem_error  in  1  fetch address fault.
- dmem_error  in  1  memory-stage address fault.
- srcA  in  4  decode read address A.
- srcB  in  4  decode read address B.
- rd_valA  out  64  regfile[srcA], or 0 if srcA==0xF.
- rd_valB  out  64  regfile[srcB], or 0 if srcB==0xF.
- pc  out  64  current PC.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- halted  out  1  high when stat != AOK.
- retired  out  64  count of committed instructions.

Behaviour:
- Reset (async, immediate, also mid-run):
  - pc=RESET_PC.
  - Regs 0-14 = 0, except reg4 = RSP_INIT.
  - stat=AOK, halted=0, retired=0.
- Instruction status (combinational), priority highest first:
  - imem_error|dmem_error -> ADR.
  - !instr_valid -> INS.
  - icode==0 -> HLT.
  - else AOK.
- Destination decode:
  - dstE:
    - icode 2 (rrmovq/cmovXX): rB if cnd, else 0xF.
    - icode 3, 6: rB.
    - icode 8, 9, A, B: 4 (%rsp).
    - else 0xF.
  - dstM:
    - icode 5, B: rA.
    - else 0xF.
- Commit on posedge clk, only when current stat==AOK and instruction status==AOK:
  - Write valE to dstE if != 0xF.
  - Write valM to dstM if != 0xF.
  - dstE==dstM (popq %rsp): valM wins.
  - Update pc:
    - call (8): valC.
    - jXX (7) with cnd=1: valC.
    - ret (9): valM.
    - else valP.
  - retired += 1, wrapping at 2^64.
- Fault or halt (instruction status != AOK while stat==AOK) on posedge:
  - Latch stat to that code.
  - No register write, pc unchanged, retired unchanged.
- stat != AOK is sticky until rst:
  - All inputs ignored; no state changes.
  - halted=1.
- Read ports are purely combinational from stored state. A write on edge N is visible on rd_valA/rd_valB only after edge N; no write-through forwarding.
- Writes to index 0xF are dropped. Reg 0xF does not exist; reads of it return 0.
- No X propagation: unused icodes with instr_valid=1 are treated as nop (pc=valP, no writes).

Test Plan:
- Reset with clk stopped:
  - Assert rst mid-cycle -> pc=0, stat=1, retired=0, rd_valA(srcA=4)=1000, rd_valB(srcB=3)=0, without a clock edge.
- irmovq 0x55 to %rbx (icode 3, rB=3, valE=0x55, valP=0x0A):
  - Posedge -> rd_valB(srcB=3)=0x55, pc=0x0A, retired=1.
  - Same-cycle read before the edge still returns 0.
- popq %rsp (icode B, rA=4, valE=1008, valM=0x77, valP=0x0C):
  - Posedge -> reg4=0x77 (valM wins), pc=0x0C.
- cmovXX with cnd=0 (icode 2, rB=5, valE=9):
  - Posedge -> reg5 unchanged.
- jXX:
  - cnd=1, valC=0x40 -> pc=0x40.
  - Then call with valC=0x80 -> pc=0x80.
  - Then ret with valM=0x14 -> pc=0x14.
- Faults:
  - mrmovq with dmem_error=1, rA=2, valM=0x99 -> stat=3, halted=1, reg2 unchanged, pc and retired frozen.
  - Subsequent valid irmovq cycles -> no change.
  - Assert rst -> AOK restored.
  - icode 0 -> stat=2.
  - instr_valid=0 -> stat=4.

Source files
------------

// File: rtl/y86_writeback_pc_update.sv
// Y86-64 SEQ write-back / PC-update stage.
// Holds the architectural state (register file, PC, status, retired count)
// and commits one instruction per clock while the processor is running.
// Once the status leaves AOK it stays there until reset.
module y86_writeback_pc_update #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter logic [63:0] RSP_INIT = 64'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        dmem_error,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] rd_valA,
    output logic [63:0] rd_valB,
    output logic [63:0] pc,
    output logic [2:0]  stat,
    output logic        halted,
    output logic [63:0] retired
);

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_t;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    // Architectural state
    logic [63:0] regs [0:14];
    logic [63:0] pc_q;
    logic [63:0] retired_q;
    stat_t       stat_q;

    // Per-instruction decode
    stat_t       inst_stat;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [63:0] next_pc;
    logic        running;
    logic        commit;
    logic        fault;

    // Classify the current instruction; address faults outrank illegal
    // encodings, which outrank halt.
    always_comb begin
        inst_stat = STAT_AOK;
        if (imem_error || dmem_error) begin
            inst_stat = STAT_ADR;
        end else if (!instr_valid) begin
            inst_stat = STAT_INS;
        end else if (icode == I_HALT) begin
            inst_stat = STAT_HLT;
        end
    end

    // Destination register selection for the ALU and memory results.
    always_comb begin
        dst_e = REG_NONE;
        dst_m = REG_NONE;
        case (icode)
            I_RRMOVQ: dst_e = cnd ? rB : REG_NONE;
            I_IRMOVQ,
            I_OPQ:    dst_e = rB;
            I_CALL,
            I_RET,
            I_PUSHQ,
            I_POPQ:   dst_e = REG_RSP;
            default:  dst_e = REG_NONE;
        endcase
        case (icode)
            I_MRMOVQ,
            I_POPQ:   dst_m = rA;
            default:  dst_m = REG_NONE;
        endcase
    end

    // Next PC: control transfers take valC or the popped return address,
    // everything else (including unused icodes) falls through to valP.
    always_comb begin
        next_pc = valP;
        case (icode)
            I_CALL:  next_pc = valC;
            I_JXX:   next_pc = cnd ? valC : valP;
            I_RET:   next_pc = valM;
            default: next_pc = valP;
        endcase
    end

    // Commit only while running and the instruction itself is clean;
    // a non-AOK instruction while running latches its status instead.
    always_comb begin
        running = (stat_q == STAT_AOK);
        commit  = running && (inst_stat == STAT_AOK);
        fault   = running && (inst_stat != STAT_AOK);
    end

    // Register file: valM is written after valE so it wins when both
    // target the same register (popq %rsp). Index 0xF is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 15; i++) begin
                regs[i[3:0]] <= (i == 4) ? RSP_INIT : '0;
            end
        end else if (commit) begin
            if (dst_e != REG_NONE) begin
                regs[dst_e] <= valE;
            end
            if (dst_m != REG_NONE) begin
                regs[dst_m] <= valM;
            end
        end
    end

    // PC, retired counter and sticky status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            retired_q <= '0;
            stat_q    <= STAT_AOK;
        end else if (commit) begin
            pc_q      <= next_pc;
            retired_q <= retired_q + 64'd1;
        end else if (fault) begin
            stat_q    <= inst_stat;
        end
    end

    // Combinational read ports straight from stored state (no forwarding).
    always_comb begin
        rd_valA = (srcA == REG_NONE) ? '0 : regs[srcA];
        rd_valB = (srcB == REG_NONE) ? '0 : regs[srcB];
    end

    assign pc      = pc_q;
    assign retired = retired_q;
    assign stat    = stat_q;
    assign halted  = (stat_q != STAT_AOK);

endmodule
